// File: rtl/parity_frame_arbiter.sv
// Round-robin arbiter that shares one bit-serial parity engine among NUM_REQ requesters.
// Each grant serialises the winner's word LSB-first and returns its parity with the winner ID.
module parity_frame_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       ser_bit,
  output logic                       ser_valid,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       parity
);

  localparam int   ID_W    = $clog2(NUM_REQ);
  localparam int   CNT_W   = $clog2(WIDTH);
  localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fold_parity(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               ser_bit_r, ser_bit_nxt_s;
  logic               ser_valid_r, ser_valid_nxt_s;
  logic               done_r, done_nxt_s;
  logic [ID_W-1:0]    done_id_r, done_id_nxt_s;
  logic               parity_r, parity_nxt_s;
  logic [WIDTH-1:0]   shift_r, shift_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               acc_r, acc_nxt_s;
  logic [ID_W-1:0]    ptr_r, ptr_nxt_s;
  logic [ID_W-1:0]    win_r, win_nxt_s;

  logic [WIDTH-1:0]       word_s [NUM_REQ];
  logic [2*NUM_REQ-1:0]   req_dbl_s;
  logic [NUM_REQ-1:0]     req_rot_s;
  logic [ID_W:0]          sum_s;
  logic [ID_W:0]          wrap_s;
  logic [ID_W-1:0]        winner_s;
  logic                   found_s;

  // Unpack the flattened data bus into per-requester words.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      word_s[k] = data[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: rotate req so ptr lands on bit 0, take the first set bit.
  always_comb begin
    req_dbl_s = {req, req} >> ptr_r;
    req_rot_s = req_dbl_s[NUM_REQ-1:0];
    found_s   = 1'b0;
    winner_s  = {ID_W{1'b0}};
    sum_s     = {(ID_W+1){1'b0}};
    wrap_s    = {(ID_W+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s    = {1'b0, ptr_r} + (ID_W+1)'(k);
      wrap_s   = (sum_s >= (ID_W+1)'(NUM_REQ)) ? (sum_s - (ID_W+1)'(NUM_REQ)) : sum_s;
      winner_s = (req_rot_s[k] && !found_s) ? wrap_s[ID_W-1:0] : winner_s;
      found_s  = found_s | req_rot_s[k];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s     = state_r;
    gnt_nxt_s       = gnt_r;
    busy_nxt_s      = busy_r;
    ser_bit_nxt_s   = 1'b0;
    ser_valid_nxt_s = 1'b0;
    done_nxt_s      = 1'b0;
    done_id_nxt_s   = done_id_r;
    parity_nxt_s    = parity_r;
    shift_nxt_s     = shift_r;
    cnt_nxt_s       = cnt_r;
    acc_nxt_s       = acc_r;
    ptr_nxt_s       = ptr_r;
    win_nxt_s       = win_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s     = SHIFT;
          gnt_nxt_s       = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
          busy_nxt_s      = 1'b1;
          shift_nxt_s     = word_s[winner_s];
          ser_bit_nxt_s   = word_s[winner_s][0];
          ser_valid_nxt_s = 1'b1;
          acc_nxt_s       = 1'b0;
          cnt_nxt_s       = {CNT_W{1'b0}};
          win_nxt_s       = winner_s;
        end else begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = {NUM_REQ{1'b0}};
          busy_nxt_s  = 1'b0;
        end
      end
      SHIFT: begin
        acc_nxt_s   = acc_r ^ shift_r[0];
        shift_nxt_s = shift_r >> 1;
        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_W'(WIDTH-1)) begin
          state_nxt_s   = DONE;
          done_nxt_s    = 1'b1;
          done_id_nxt_s = win_r;
          parity_nxt_s  = fold_parity(acc_r ^ shift_r[0], ODD_BIT);
          ptr_nxt_s     = (win_r == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : (win_r + {{(ID_W-1){1'b0}}, 1'b1});
        end else begin
          ser_valid_nxt_s = 1'b1;
          ser_bit_nxt_s   = shift_r[1];
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      busy_r      <= 1'b0;
      ser_bit_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= {ID_W{1'b0}};
      parity_r    <= 1'b0;
      shift_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= 1'b0;
      ptr_r       <= {ID_W{1'b0}};
      win_r       <= {ID_W{1'b0}};
    end else begin
      gnt_r       <= gnt_nxt_s;
      busy_r      <= busy_nxt_s;
      ser_bit_r   <= ser_bit_nxt_s;
      ser_valid_r <= ser_valid_nxt_s;
      done_r      <= done_nxt_s;
      done_id_r   <= done_id_nxt_s;
      parity_r    <= parity_nxt_s;
      shift_r     <= shift_nxt_s;
      cnt_r       <= cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      ptr_r       <= ptr_nxt_s;
      win_r       <= win_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign ser_bit   = ser_bit_r;
  assign ser_valid = ser_valid_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign parity    = parity_r;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Directed scoreboard bench for parity_frame_arbiter; an even- and an odd-parity instance
// share the same stimulus, and each completion is matched against queued expectations.
module tb_parity_frame_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;

  logic [N-1:0] gnt_e, gnt_o;
  logic         busy_e, busy_o, ser_bit_e, ser_bit_o, ser_valid_e, ser_valid_o;
  logic         done_e, done_o, parity_e, parity_o;
  logic [1:0]   done_id_e, done_id_o;

  typedef struct {
    int         id;
    logic [7:0] w;
  } exp_t;

  exp_t sbq[$];
  int   done_t[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  parity_frame_arbiter #(.NUM_REQ(N), .WIDTH(W), .PARITY_ODD(0)) dut_e (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .gnt(gnt_e), .busy(busy_e), .ser_bit(ser_bit_e), .ser_valid(ser_valid_e),
    .done(done_e), .done_id(done_id_e), .parity(parity_e));

  parity_frame_arbiter #(.NUM_REQ(N), .WIDTH(W), .PARITY_ODD(1)) dut_o (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .gnt(gnt_o), .busy(busy_o), .ser_bit(ser_bit_o), .ser_valid(ser_valid_o),
    .done(done_o), .done_id(done_id_o), .parity(parity_o));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse pops one expectation; grants must stay one-hot or zero.
  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt_e)), 32'd1);
    if (done_e === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 32'(sbq.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_id", 32'(done_id_e), 32'(e.id));
        chk("parity_even", 32'(parity_e), 32'(^e.w));
        chk("parity_odd", 32'(parity_o), 32'(~^e.w));
        chk("done_odd_inst", 32'(done_o), 32'd1);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'({gnt_o, gnt_e}), 32'd0);
    chk({tag, "_flags"}, 32'({busy_e, busy_o, ser_bit_e, ser_bit_o, ser_valid_e, ser_valid_o}), 32'd0);
    chk({tag, "_done"}, 32'({done_e, done_o, done_id_e, done_id_o, parity_e, parity_o}), 32'd0);
  endtask

  // One full transaction from IDLE; optionally disturb data/req while it runs.
  task automatic xact(input int id, input logic [7:0] w, input bit midchg);
    data[id*W +: W] = w;
    req = 4'b0001 << id;
    sbq.push_back('{id, w});
    tick();
    chk("grant", 32'(gnt_e), 32'(4'b0001 << id));
    chk("busy_on", 32'(busy_e), 32'd1);
    for (int i = 0; i < W; i++) begin
      chk("ser_valid", 32'(ser_valid_e), 32'd1);
      chk("ser_bit", 32'(ser_bit_e), 32'(w[i]));
      if (midchg && i == 2) data[id*W +: W] = w ^ 8'h01;
      if (midchg && i == 3) req = 4'b0000;
      tick();
    end
    chk("done_pulse", 32'(done_e), 32'd1);
    chk("ser_valid_off", 32'(ser_valid_e), 32'd0);
    chk("gnt_in_done", 32'(gnt_e), 32'(4'b0001 << id));
    req = 4'b0000;
    tick();
    chk("busy_off", 32'(busy_e), 32'd0);
    chk("gnt_off", 32'(gnt_e), 32'd0);
  endtask

  // Wait (bounded) for n done pulses, logging their cycles; req drops on the last one.
  task automatic wait_dones(input int n);
    int got;
    got = 0;
    done_t.delete();
    for (int c = 0; c < 200 && got < n; c++) begin
      tick();
      if (done_e === 1'b1) begin
        done_t.push_back(cyc);
        got++;
        if (got == n) req = 4'b0000;
      end
    end
    chk("done_count", 32'(got), 32'(n));
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    data  = 32'h0000_0000;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    xact(0, 8'hA5, 1'b0);
    xact(2, 8'h07, 1'b0);
    xact(2, 8'h00, 1'b0);

    // Continuous requests from everyone: rotation 0,1,2,3,0 at WIDTH+2 spacing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data = 32'h0F_3C_81_E7;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) sbq.push_back('{k % N, data[(k % N)*W +: W]});
    wait_dones(5);
    for (int k = 1; k < done_t.size(); k++) chk("rr_spacing", 32'(done_t[k] - done_t[k-1]), 32'd10);
    tick();

    // Pointer sits at 2 after requester 1; req 0011 must wrap to 0 and then 1.
    xact(1, 8'h5A, 1'b0);
    data[0 +: W] = 8'h13;
    data[W +: W] = 8'h6E;
    req = 4'b0011;
    sbq.push_back('{0, 8'h13});
    sbq.push_back('{1, 8'h6E});
    wait_dones(2);
    tick();

    xact(3, 8'h38, 1'b1);

    // Reset mid-SHIFT with pointer at 2: no done, and pointer returns to 0.
    xact(1, 8'hC3, 1'b0);
    data[2*W +: W] = 8'hF0;
    req = 4'b0100;
    tick();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    req   = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_done_after_reset", 32'(done_e), 32'd0);
    end
    data[0 +: W] = 8'h81;
    req = 4'b0101;
    sbq.push_back('{0, 8'h81});
    tick();
    chk("grant_after_reset", 32'(gnt_e), 32'(4'b0001));
    wait_dones(1);
    tick();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
